// File: rtl/exc_monitor_if.sv
// ============================================================================
// Module : exc_monitor_if
// Brief  : CPU-side bundle between the exception vector / PC and exc_monitor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface exc_monitor_if #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_EXC    = 8
);
   localparam int c_CAUSE_W = $clog2(NUM_EXC) + 1;

   logic [DATA_WIDTH-1:0] pc_i;
   logic [NUM_EXC-1:0]    exc_i;
   logic                  resume_i;
   logic                  pc_we_o;
   logic [1:0]            state_o;
   logic [1:0]            nstate_o;
   logic [c_CAUSE_W-1:0]  cause_o;
   logic [DATA_WIDTH-1:0] epc_o;
   logic [15:0]           trap_cnt_o;

   modport master (
      output pc_i, exc_i, resume_i,
      input  pc_we_o, state_o, nstate_o, cause_o, epc_o, trap_cnt_o
   );

   modport slave (
      input  pc_i, exc_i, resume_i,
      output pc_we_o, state_o, nstate_o, cause_o, epc_o, trap_cnt_o
   );
endinterface

`default_nettype wire

// File: rtl/exc_monitor.sv
// ============================================================================
// Module : exc_monitor
// Brief  : Trap/exception monitor owning the core run state (RST/NORMAL/HALT/
//          ERROR), with EPC capture, cause encoding and a saturating trap
//          counter. Optional HALT watchdog: define MONITOR_WATCHDOG_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exc_monitor #(
   parameter int                 DATA_WIDTH = 64,
   parameter int                 NUM_EXC    = 8,
   parameter logic [NUM_EXC-1:0] FATAL_MASK = 8'b0000_0111,
   parameter logic [NUM_EXC-1:0] HALT_MASK  = 8'b0001_1000,
   parameter int                 WDT_CYCLES = 1024
) (
   input wire logic      clk_i,
   input wire logic      rst_i,
   exc_monitor_if.slave  mon
);
   localparam int c_CW = $clog2(NUM_EXC) + 1;

   typedef enum logic [1:0] {
      ST_RST    = 2'd0,
      ST_NORMAL = 2'd1,
      ST_HALT   = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   state_t                r_state;
   logic [c_CW-1:0]       r_cause;
   logic [DATA_WIDTH-1:0] r_epc;
   logic [15:0]           r_trap_cnt;

   state_t                w_nstate;
   logic [NUM_EXC-1:0]    w_fatal;
   logic [NUM_EXC-1:0]    w_halt;
   logic                  w_wdt_expire;
   logic                  w_trap_entry;
   logic [c_CW-1:0]       w_cause_next;

   function automatic logic [c_CW-1:0] f_lowest(input logic [NUM_EXC-1:0] v);
      logic [c_CW-1:0] idx;
      idx = '0;
      for (int i = NUM_EXC - 1; i >= 0; i--) begin
         if (v[i]) idx = c_CW'(i);
      end
      return idx;
   endfunction

   // A bit present in both masks is treated as fatal only.
   assign w_fatal = mon.exc_i & FATAL_MASK;
   assign w_halt  = mon.exc_i & HALT_MASK & ~FATAL_MASK;

`ifdef MONITOR_WATCHDOG_EN
   localparam int c_WDT_W = $clog2(WDT_CYCLES + 1);
   logic [c_WDT_W-1:0] r_wdt;

   assign w_wdt_expire = (r_state == ST_HALT) &&
                         (r_wdt == c_WDT_W'(WDT_CYCLES - 1));
`else
   logic w_unused_wdt;

   assign w_wdt_expire = 1'b0;
   assign w_unused_wdt = (WDT_CYCLES > 0);
`endif

   always_comb begin
      w_nstate = r_state;
      case (r_state)
         ST_RST:    w_nstate = ST_NORMAL;
         ST_NORMAL: begin
            if (w_fatal != '0)     w_nstate = ST_ERROR;
            else if (w_halt != '0) w_nstate = ST_HALT;
         end
         ST_HALT: begin
            if (mon.resume_i)      w_nstate = ST_NORMAL;
            else if (w_wdt_expire) w_nstate = ST_ERROR;
         end
         default:   w_nstate = ST_ERROR;
      endcase
   end

   always_comb begin
      w_trap_entry = ((r_state == ST_NORMAL) && ((w_fatal | w_halt) != '0)) ||
                     ((r_state == ST_HALT) && !mon.resume_i && w_wdt_expire);
      w_cause_next = (w_fatal != '0) ? f_lowest(w_fatal) : f_lowest(w_halt);
      // The only trap taken from HALT is the watchdog expiry.
      if (r_state == ST_HALT) w_cause_next = c_CW'(NUM_EXC);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= ST_RST;
         r_cause    <= '0;
         r_epc      <= '0;
         r_trap_cnt <= '0;
`ifdef MONITOR_WATCHDOG_EN
         r_wdt      <= '0;
`endif
      end else begin
         r_state <= w_nstate;
         if (w_trap_entry) begin
            r_cause <= w_cause_next;
            if (r_state == ST_NORMAL) r_epc <= mon.pc_i;
            if (r_trap_cnt != 16'hFFFF) r_trap_cnt <= r_trap_cnt + 16'd1;
         end
`ifdef MONITOR_WATCHDOG_EN
         if (r_state == ST_HALT) r_wdt <= r_wdt + 1'b1;
         else                    r_wdt <= '0;
`endif
      end
   end

   // The trapping instruction must never commit a new PC.
   assign mon.pc_we_o    = (r_state == ST_NORMAL) && (w_fatal == '0) && (w_halt == '0);
   assign mon.state_o    = r_state;
   assign mon.nstate_o   = w_nstate;
   assign mon.cause_o    = r_cause;
   assign mon.epc_o      = r_epc;
   assign mon.trap_cnt_o = r_trap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_exc_monitor.sv
// ============================================================================
// Module : tb_exc_monitor
// Brief  : Directed scoreboard bench for exc_monitor (WDT_CYCLES=16).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_exc_monitor;
   logic clk;
   logic rst;
   int   cyc_id;
   int   total;
   int   bad;

   exc_monitor_if #(.DATA_WIDTH(64), .NUM_EXC(8)) bus ();

   exc_monitor #(
      .DATA_WIDTH (64),
      .NUM_EXC    (8),
      .FATAL_MASK (8'b0000_0111),
      .HALT_MASK  (8'b0001_1000),
      .WDT_CYCLES (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .mon   (bus.slave)
   );

   typedef struct {
      int          tag;
      logic [1:0]  st;
      logic [1:0]  ns;
      logic        we;
      logic [3:0]  cause;
      logic [63:0] epc;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc_id = 0;
   always @(posedge clk) cyc_id <= cyc_id + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc_id, act, exp);
      end
   endtask

   // Monitor: checks the snapshot queued for the current cycle, mid-cycle.
   always @(negedge clk) begin
      exp_t x;
      if (q.size() != 0) begin
         if (q[0].tag == cyc_id) begin
            x = q.pop_front();
            chk("state",  {62'd0, bus.state_o},  {62'd0, x.st});
            chk("nstate", {62'd0, bus.nstate_o}, {62'd0, x.ns});
            chk("pc_we",  {63'd0, bus.pc_we_o},  {63'd0, x.we});
            chk("cause",  {60'd0, bus.cause_o},  {60'd0, x.cause});
            chk("epc",    bus.epc_o,             x.epc);
            chk("cnt",    {48'd0, bus.trap_cnt_o}, {48'd0, x.cnt});
         end else if (q[0].tag < cyc_id) begin
            x = q.pop_front();
            total++;
            bad++;
            $display("FAIL stale_entry tag=%0d now=%0d", x.tag, cyc_id);
         end
      end
   end

   task automatic cyc(input logic r, input logic [63:0] pc, input logic [7:0] exc,
                      input logic res, input logic [1:0] st, input logic [1:0] ns,
                      input logic we, input logic [3:0] c, input logic [63:0] e,
                      input logic [15:0] n);
      exp_t x;
      @(posedge clk);
      #1;
      rst          = r;
      bus.pc_i     = pc;
      bus.exc_i    = exc;
      bus.resume_i = res;
      x.tag = cyc_id; x.st = st; x.ns = ns; x.we = we;
      x.cause = c; x.epc = e; x.cnt = n;
      q.push_back(x);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  hc;
      logic [63:0] he;
      logic [15:0] hn;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.pc_i = '0; bus.exc_i = '0; bus.resume_i = 1'b0;

      //  rst pc             exc    res st  ns  we cause epc            cnt
      cyc(1, 64'h0,          8'h00, 0, 0, 1, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 0, 1, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h100,        8'h00, 0, 1, 1, 1, 0, 64'h0,          16'd0);
      cyc(0, 64'h8000_0010,  8'h08, 0, 1, 2, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 2, 2, 0, 3, 64'h8000_0010,  16'd1);
      cyc(0, 64'h0,          8'h01, 0, 2, 2, 0, 3, 64'h8000_0010,  16'd1);
      cyc(0, 64'h0,          8'h00, 1, 2, 1, 0, 3, 64'h8000_0010,  16'd1);
      cyc(0, 64'h8000_0020,  8'h10, 0, 1, 2, 0, 3, 64'h8000_0010,  16'd1);
      cyc(0, 64'h0,          8'h00, 0, 2, 2, 0, 4, 64'h8000_0020,  16'd2);
      cyc(0, 64'h0,          8'h00, 1, 2, 1, 0, 4, 64'h8000_0020,  16'd2);
      cyc(0, 64'h8000_0030,  8'h00, 1, 1, 1, 1, 4, 64'h8000_0020,  16'd2);
      cyc(0, 64'h8000_0040,  8'h1A, 0, 1, 3, 0, 4, 64'h8000_0020,  16'd2);
      cyc(0, 64'h0,          8'h08, 1, 3, 3, 0, 1, 64'h8000_0040,  16'd3);
      cyc(0, 64'h0,          8'hFF, 0, 3, 3, 0, 1, 64'h8000_0040,  16'd3);
      // Mid-cycle reset out of ERROR takes effect before the next edge.
      cyc(1, 64'h0,          8'h00, 0, 0, 1, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 0, 1, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 1, 1, 1, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h20, 0, 1, 1, 1, 0, 64'h0,          16'd0);
      cyc(0, 64'h8000_0050,  8'h18, 0, 1, 2, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 2, 2, 0, 3, 64'h8000_0050,  16'd1);

`ifdef MONITOR_WATCHDOG_EN
      for (int i = 2; i <= 15; i++)
         cyc(0, 64'h0, 8'h00, 0, 2, 2, 0, 3, 64'h8000_0050, 16'd1);
      cyc(0, 64'h0,          8'h00, 0, 2, 3, 0, 3, 64'h8000_0050,  16'd1);
      cyc(0, 64'h0,          8'h00, 0, 3, 3, 0, 8, 64'h8000_0050,  16'd2);
      cyc(1, 64'h0,          8'h00, 0, 0, 1, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 0, 1, 0, 0, 64'h0,          16'd0);
      cyc(0, 64'h0,          8'h00, 0, 1, 1, 1, 0, 64'h0,          16'd0);
      cyc(0, 64'h8000_0060,  8'h08, 0, 1, 2, 0, 0, 64'h0,          16'd0);
      for (int i = 1; i <= 15; i++)
         cyc(0, 64'h0, 8'h00, 0, 2, 2, 0, 3, 64'h8000_0060, 16'd1);
      cyc(0, 64'h0,          8'h00, 1, 2, 1, 0, 3, 64'h8000_0060,  16'd1);
      hc = 4'd3; he = 64'h8000_0060; hn = 16'd1;
`else
      for (int i = 0; i < 40; i++)
         cyc(0, 64'h0, 8'h00, 0, 2, 2, 0, 3, 64'h8000_0050, 16'd1);
      cyc(0, 64'h0,          8'h00, 1, 2, 1, 0, 3, 64'h8000_0050,  16'd1);
      hc = 4'd3; he = 64'h8000_0050; hn = 16'd1;
`endif

      // Trap in the first NORMAL cycle after resume, then counter saturation.
      cyc(0, 64'h8000_0070,  8'h08, 0, 1, 2, 0, hc, he,            hn);
      cyc(0, 64'h0,          8'h00, 1, 2, 1, 0, 3, 64'h8000_0070,  hn + 16'd1);
      cyc(0, 64'h0,          8'h00, 0, 1, 1, 1, 3, 64'h8000_0070,  16'hFFFE);
      force dut.r_trap_cnt = 16'hFFFE;
      #1;
      release dut.r_trap_cnt;
      cyc(0, 64'h8000_0080,  8'h10, 0, 1, 2, 0, 3, 64'h8000_0070,  16'hFFFE);
      cyc(0, 64'h0,          8'h00, 1, 2, 1, 0, 4, 64'h8000_0080,  16'hFFFF);
      cyc(0, 64'h8000_0090,  8'h08, 0, 1, 2, 0, 4, 64'h8000_0080,  16'hFFFF);
      cyc(0, 64'h0,          8'h00, 0, 2, 2, 0, 3, 64'h8000_0090,  16'hFFFF);

      repeat (3) @(posedge clk);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain got=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
